// File: rtl/frame_ram_pkg.sv
// Shared types and constants for the frame RAM arbiter: default widths,
// requester encoding and RGB field positions within a pixel.
package frame_ram_pkg;

    localparam int ADDR_W_DEF = 26;
    localparam int PIX_W_DEF  = 24;

    localparam int RED_HI   = 23;
    localparam int RED_LO   = 16;
    localparam int GREEN_HI = 15;
    localparam int GREEN_LO = 8;
    localparam int BLUE_HI  = 7;
    localparam int BLUE_LO  = 0;

    typedef enum logic [1:0] {
        REQ_NONE,
        REQ_DISP,
        REQ_CAM0,
        REQ_CAM1
    } req_t;

    function automatic logic [PIX_W_DEF-1:0] pix_rgb(input logic [7:0] r,
                                                     input logic [7:0] g,
                                                     input logic [7:0] b);
        logic [PIX_W_DEF-1:0] p;
        p                    = '0;
        p[RED_HI:RED_LO]     = r;
        p[GREEN_HI:GREEN_LO] = g;
        p[BLUE_HI:BLUE_LO]   = b;
        return p;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, pointer advances past the
// winner. en low suppresses all grants and freezes the pointer.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic ptr;  // 0: requester 0 has priority, 1: requester 1

    always_comb begin
        // NOTE: assign a default first so no path leaves gnt unassigned (no latch).
        gnt = 2'b00;
        if (en) begin
            if (!ptr) gnt = req[0] ? 2'b01 : (req[1] ? 2'b10 : 2'b00);
            else      gnt = req[1] ? 2'b10 : (req[0] ? 2'b01 : 2'b00);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n)      ptr <= 1'b0;
        else if (gnt[0]) ptr <= 1'b1;
        else if (gnt[1]) ptr <= 1'b0;
    end

endmodule

// File: rtl/frame_ram_arbiter.sv
// Single-port frame RAM arbiter: display reads first, cameras round-robin,
// fixed-latency pixel return. Optional stats via FRAME_RAM_ARB_STATS_EN.
module frame_ram_arbiter
    import frame_ram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int PIX_W  = PIX_W_DEF,
    parameter int RD_LAT = 2
`ifdef FRAME_RAM_ARB_STATS_EN
    , parameter int STARVE_LIMIT = 1023
`endif
) (
    input  logic              clk_low,
    input  logic              reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [PIX_W-1:0]  disp_data,
    output logic              disp_valid,
    input  logic              cam0_req,
    input  logic [ADDR_W-1:0] cam0_addr,
    input  logic [PIX_W-1:0]  cam0_data,
    output logic              cam0_gnt,
    input  logic              cam1_req,
    input  logic [ADDR_W-1:0] cam1_addr,
    input  logic [PIX_W-1:0]  cam1_data,
    output logic              cam1_gnt,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [PIX_W-1:0]  ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [PIX_W-1:0]  ram_rdata
`ifdef FRAME_RAM_ARB_STATS_EN
    ,
    output logic              cam0_starve,
    output logic              cam1_starve,
    output logic [31:0]       grant_cnt
`endif
);

    logic [1:0]        cam_gnt;
    logic              arb_en;
    req_t              winner;
    logic [RD_LAT-1:0] vld_pipe;

    // Reset gates the cameras too, so grants stay low while reset is held.
    assign arb_en = reset & ~disp_req;

    rr_arb2 u_rr_arb2 (
        .clk   (clk_low),
        .rst_n (reset),
        .en    (arb_en),
        .req   ({cam1_req, cam0_req}),
        .gnt   (cam_gnt)
    );

    assign cam0_gnt = cam_gnt[0];
    assign cam1_gnt = cam_gnt[1];

    always_comb begin
        winner = REQ_NONE;
        if (disp_req)        winner = REQ_DISP;
        else if (cam_gnt[0]) winner = REQ_CAM0;
        else if (cam_gnt[1]) winner = REQ_CAM1;
    end

    // RAM command, one cycle after the grant; address/data hold when idle.
    always_ff @(posedge clk_low or negedge reset) begin
        if (!reset) begin
            ram_re    <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_re <= (winner == REQ_DISP);
            ram_we <= (winner == REQ_CAM0) || (winner == REQ_CAM1);
            case (winner)
                REQ_DISP: ram_addr <= disp_addr;
                REQ_CAM0: begin
                    ram_addr  <= cam0_addr;
                    ram_wdata <= cam0_data;
                end
                REQ_CAM1: begin
                    ram_addr  <= cam1_addr;
                    ram_wdata <= cam1_data;
                end
                default: ;
            endcase
        end
    end

    // Valid bits shadow each ram_re through the RAM latency.
    always_ff @(posedge clk_low or negedge reset) begin
        if (!reset) begin
            vld_pipe   <= '0;
            disp_valid <= 1'b0;
            disp_data  <= '0;
        end else begin
            vld_pipe[0] <= ram_re;
            for (int i = 1; i < RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
            disp_valid <= vld_pipe[RD_LAT-1];
            if (vld_pipe[RD_LAT-1]) disp_data <= ram_rdata;
        end
    end

`ifdef FRAME_RAM_ARB_STATS_EN
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    logic [WAIT_W-1:0] wait0, wait1, wait0_nxt, wait1_nxt;

    function automatic logic [WAIT_W-1:0] next_wait(input logic [WAIT_W-1:0] w,
                                                    input logic req,
                                                    input logic gnt);
        if (gnt)                        return '0;
        else if (req && w != WAIT_MAX)  return w + 1'b1;
        else                            return w;
    endfunction

    assign wait0_nxt = next_wait(wait0, cam0_req, cam_gnt[0]);
    assign wait1_nxt = next_wait(wait1, cam1_req, cam_gnt[1]);

    always_ff @(posedge clk_low or negedge reset) begin
        if (!reset) begin
            wait0       <= '0;
            wait1       <= '0;
            cam0_starve <= 1'b0;
            cam1_starve <= 1'b0;
            grant_cnt   <= '0;
        end else begin
            wait0       <= wait0_nxt;
            wait1       <= wait1_nxt;
            cam0_starve <= cam0_starve | (wait0_nxt == WAIT_MAX);
            cam1_starve <= cam1_starve | (wait1_nxt == WAIT_MAX);
            grant_cnt   <= grant_cnt + 32'(winner != REQ_NONE);
        end
    end
`endif

endmodule

// File: tb/tb_frame_ram_arbiter.sv
// Directed bench for frame_ram_arbiter: per-cycle vector table plus a
// hand-written reset-during-reads sequence, against a RD_LAT=2 RAM model.
module tb_frame_ram_arbiter;
    import frame_ram_pkg::*;

    localparam int ADDR_W = 26;
    localparam int PIX_W  = 24;

    logic              clk_low = 1'b0;
    logic              reset;
    logic              disp_req;
    logic [ADDR_W-1:0] disp_addr;
    logic [PIX_W-1:0]  disp_data;
    logic              disp_valid;
    logic              cam0_req, cam1_req;
    logic [ADDR_W-1:0] cam0_addr, cam1_addr;
    logic [PIX_W-1:0]  cam0_data, cam1_data;
    logic              cam0_gnt, cam1_gnt;
    logic [ADDR_W-1:0] ram_addr;
    logic [PIX_W-1:0]  ram_wdata;
    logic              ram_we, ram_re;
    logic [PIX_W-1:0]  ram_rdata;
`ifdef FRAME_RAM_ARB_STATS_EN
    logic              cam0_starve, cam1_starve;
    logic [31:0]       grant_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk_low = ~clk_low;

    frame_ram_arbiter #(.ADDR_W(ADDR_W), .PIX_W(PIX_W), .RD_LAT(2)) dut (
        .clk_low    (clk_low),
        .reset      (reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .cam0_req   (cam0_req),
        .cam0_addr  (cam0_addr),
        .cam0_data  (cam0_data),
        .cam0_gnt   (cam0_gnt),
        .cam1_req   (cam1_req),
        .cam1_addr  (cam1_addr),
        .cam1_data  (cam1_data),
        .cam1_gnt   (cam1_gnt),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_we     (ram_we),
        .ram_re     (ram_re),
        .ram_rdata  (ram_rdata)
`ifdef FRAME_RAM_ARB_STATS_EN
        ,
        .cam0_starve(cam0_starve),
        .cam1_starve(cam1_starve),
        .grant_cnt  (grant_cnt)
`endif
    );

    // Unwritten locations read back as 0x5A0000 | address.
    function automatic logic [23:0] md(input int i);
        return 24'h5A0000 | 24'(i);
    endfunction

    // RAM model: two-cycle read latency, writes on ram_we.
    logic [23:0] wr_mem [64];
    logic [63:0] written;
    logic [23:0] rd_p1;
    always @(posedge clk_low) begin
        if (!reset) written <= '0;
        else if (ram_we) begin
            wr_mem[ram_addr[5:0]]  <= ram_wdata;
            written[ram_addr[5:0]] <= 1'b1;
        end
        rd_p1     <= written[ram_addr[5:0]] ? wr_mem[ram_addr[5:0]] : md(int'(ram_addr[5:0]));
        ram_rdata <= rd_p1;
    end

    typedef struct {
        logic        dr;
        logic [7:0]  da;
        logic        c0r, c1r;
        logic [7:0]  c0a, c1a;
        logic [23:0] c0d, c1d;
        logic        g0, g1, re, we;
        logic [7:0]  ea;
        logic [23:0] ew;
        logic        dv;
        logic [23:0] dd;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  cur_c0a, cur_c1a;
    logic [23:0] cur_c0d, cur_c1d;

    task automatic add(input logic dr, input logic [7:0] da, input logic c0r, input logic c1r,
                       input logic g0, input logic g1, input logic re, input logic we,
                       input logic [7:0] ea, input logic [23:0] ew,
                       input logic dv, input logic [23:0] dd);
        vec_t v;
        v.dr = dr; v.da = da; v.c0r = c0r; v.c1r = c1r;
        v.c0a = cur_c0a; v.c1a = cur_c1a; v.c0d = cur_c0d; v.c1d = cur_c1d;
        v.g0 = g0; v.g1 = g1; v.re = re; v.we = we;
        v.ea = ea; v.ew = ew; v.dv = dv; v.dd = dd;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [23:0] c0d, c1d, red, green;
        c0d   = pix_rgb(8'h00, 8'h00, 8'hC0);
        c1d   = pix_rgb(8'h00, 8'h00, 8'hC1);
        red   = pix_rgb(8'hFF, 8'h00, 8'h00);
        green = pix_rgb(8'h00, 8'hFF, 8'h00);

        // Phase A: continuous display reads 0..5, then idle.
        cur_c0a = 8'h20; cur_c0d = c0d; cur_c1a = 8'h21; cur_c1d = c1d;
        add(1, 0, 0, 0,  0, 0, 0, 0, 8'h00, 24'h0, 0, 24'h0);
        add(1, 1, 0, 0,  0, 0, 1, 0, 8'h00, 24'h0, 0, 24'h0);
        add(1, 2, 0, 0,  0, 0, 1, 0, 8'h01, 24'h0, 0, 24'h0);
        add(1, 3, 0, 0,  0, 0, 1, 0, 8'h02, 24'h0, 0, 24'h0);
        add(1, 4, 0, 0,  0, 0, 1, 0, 8'h03, 24'h0, 1, md(0));
        add(1, 5, 0, 0,  0, 0, 1, 0, 8'h04, 24'h0, 1, md(1));
        add(0, 0, 0, 0,  0, 0, 1, 0, 8'h05, 24'h0, 1, md(2));
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h05, 24'h0, 1, md(3));
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h05, 24'h0, 1, md(4));
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h05, 24'h0, 1, md(5));
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h05, 24'h0, 0, md(5));
        // Phase B: both cameras, no display -> cam0, cam1, cam0, cam1.
        add(0, 0, 1, 1,  1, 0, 0, 0, 8'h05, 24'h0, 0, md(5));
        add(0, 0, 1, 1,  0, 1, 0, 1, 8'h20, c0d,   0, md(5));
        add(0, 0, 1, 1,  1, 0, 0, 1, 8'h21, c1d,   0, md(5));
        add(0, 0, 1, 1,  0, 1, 0, 1, 8'h20, c0d,   0, md(5));
        add(0, 0, 0, 0,  0, 0, 0, 1, 8'h21, c1d,   0, md(5));
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h21, c1d,   0, md(5));
        // Phase C: display toggling, cameras take the free slots alternately.
        add(1, 6, 1, 1,  0, 0, 0, 0, 8'h21, c1d,   0, md(5));
        add(0, 0, 1, 1,  1, 0, 1, 0, 8'h06, c1d,   0, md(5));
        add(1, 7, 1, 1,  0, 0, 0, 1, 8'h20, c0d,   0, md(5));
        add(0, 0, 1, 1,  0, 1, 1, 0, 8'h07, c0d,   0, md(5));
        add(1, 8, 1, 1,  0, 0, 0, 1, 8'h21, c1d,   1, md(6));
        add(0, 0, 0, 0,  0, 0, 1, 0, 8'h08, c1d,   0, md(6));
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h08, c1d,   1, md(7));
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h08, c1d,   0, md(7));
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h08, c1d,   1, md(8));
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h08, c1d,   0, md(8));
        // Phase D: same-address write/read ordering at address 5.
        cur_c0a = 8'h05; cur_c0d = green; cur_c1a = 8'h05; cur_c1d = red;
        add(0, 0, 0, 1,  0, 1, 0, 0, 8'h08, c1d,   0, md(8));
        add(1, 5, 0, 0,  0, 0, 0, 1, 8'h05, red,   0, md(8));
        add(1, 5, 1, 0,  0, 0, 1, 0, 8'h05, red,   0, md(8));
        add(0, 0, 1, 0,  1, 0, 1, 0, 8'h05, red,   0, md(8));
        add(0, 0, 0, 0,  0, 0, 0, 1, 8'h05, green, 0, md(8));
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h05, green, 1, red);
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h05, green, 1, red);
        add(1, 5, 0, 0,  0, 0, 0, 0, 8'h05, green, 0, red);
        add(0, 0, 0, 0,  0, 0, 1, 0, 8'h05, green, 0, red);
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h05, green, 0, red);
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h05, green, 0, red);
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h05, green, 1, green);
        add(0, 0, 0, 0,  0, 0, 0, 0, 8'h05, green, 0, green);

        reset = 1'b0; disp_req = 1'b0; disp_addr = '0;
        cam0_req = 1'b0; cam1_req = 1'b0;
        cam0_addr = '0; cam1_addr = '0; cam0_data = '0; cam1_data = '0;
        @(negedge clk_low);
        check("rst.disp_valid", disp_valid, 0);
        check("rst.ram_re", ram_re, 0);
        check("rst.ram_we", ram_we, 0);
        @(posedge clk_low); #1;
        reset = 1'b1;

        foreach (vecs[i]) begin
            disp_req  = vecs[i].dr;
            disp_addr = ADDR_W'(vecs[i].da);
            cam0_req  = vecs[i].c0r;  cam1_req  = vecs[i].c1r;
            cam0_addr = ADDR_W'(vecs[i].c0a); cam1_addr = ADDR_W'(vecs[i].c1a);
            cam0_data = vecs[i].c0d;  cam1_data = vecs[i].c1d;
            @(negedge clk_low);
            check($sformatf("row%0d.cam0_gnt", i),   cam0_gnt,   vecs[i].g0);
            check($sformatf("row%0d.cam1_gnt", i),   cam1_gnt,   vecs[i].g1);
            check($sformatf("row%0d.ram_re", i),     ram_re,     vecs[i].re);
            check($sformatf("row%0d.ram_we", i),     ram_we,     vecs[i].we);
            check($sformatf("row%0d.ram_addr", i),   ram_addr,   vecs[i].ea);
            check($sformatf("row%0d.ram_wdata", i),  ram_wdata,  vecs[i].ew);
            check($sformatf("row%0d.disp_valid", i), disp_valid, vecs[i].dv);
            check($sformatf("row%0d.disp_data", i),  disp_data,  vecs[i].dd);
            @(posedge clk_low); #1;
        end

        // Reset one cycle after three reads: no ghost disp_valid afterwards.
        for (int k = 1; k <= 3; k++) begin
            disp_req = 1'b1; disp_addr = ADDR_W'(k);
            @(posedge clk_low); #1;
        end
        disp_req = 1'b0;
        @(posedge clk_low); #1;
        cam0_req = 1'b1; cam1_req = 1'b1;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk_low);
            check($sformatf("inrst%0d.disp_valid", k), disp_valid, 0);
            check($sformatf("inrst%0d.disp_data", k),  disp_data,  0);
            check($sformatf("inrst%0d.ram_re", k),     ram_re,     0);
            check($sformatf("inrst%0d.ram_we", k),     ram_we,     0);
            check($sformatf("inrst%0d.ram_addr", k),   ram_addr,   0);
            check($sformatf("inrst%0d.ram_wdata", k),  ram_wdata,  0);
            check($sformatf("inrst%0d.cam0_gnt", k),   cam0_gnt,   0);
            check($sformatf("inrst%0d.cam1_gnt", k),   cam1_gnt,   0);
            @(posedge clk_low); #1;
        end
        cam0_req = 1'b0; cam1_req = 1'b0;
        reset = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_low);
            check($sformatf("postrst%0d.disp_valid", k), disp_valid, 0);
            @(posedge clk_low); #1;
        end
        // Pointer returns to cam0 after reset.
        cam0_req = 1'b1; cam1_req = 1'b1;
        @(negedge clk_low);
        check("rrreset.cam0_gnt", cam0_gnt, 1);
        check("rrreset.cam1_gnt", cam1_gnt, 0);
        @(posedge clk_low); #1;
        cam0_req = 1'b0; cam1_req = 1'b0;
        @(negedge clk_low);
        check("rrreset.ram_we", ram_we, 1);
        check("rrreset.ram_wdata", ram_wdata, green);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/frame_ram_arbiter.md
Name: frame_ram_arbiter

Overview:
- Shares the single-port frame RAM between the HDMI display reader and the two camera write ports (left = cam0, right = cam1).
- Display reads have strict priority; the cameras share leftover slots round-robin.
- Returns display pixels with fixed latency, so the TMDS path never sees a late pixel.
- Sits between the HDMI transceiver address/data port, the camera capture blocks and the RAM controller.

Parameters:
- ADDR_W, 26, pixel address width (matches the transceiver ram_addr).
- PIX_W, 24, pixel width: {red[23:16], green[15:8], blue[7:0]}.
- RD_LAT, 2, RAM read latency in cycles from ram_re to valid ram_rdata; must be >=1.
- STARVE_LIMIT, 1023, wait cycles before the starvation flag (optional feature only).

Ports:
- clk_low  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- disp_req  in  1  display read request, one pixel per cycle.
- disp_addr  in  ADDR_W  display read address.
- disp_data  out  PIX_W  returned pixel.
- disp_valid  out  1  disp_data valid.
- cam0_req  in  1  camera 0 write request.
- cam0_addr  in  ADDR_W  write address.
- cam0_data  in  PIX_W  write data.
- cam0_gnt  out  1  camera 0 write accepted this cycle.
- cam1_req, cam1_addr, cam1_data, cam1_gnt: same as cam0, for camera 1.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  PIX_W  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_rdata  in  PIX_W  RAM read data.

Behaviour:
- Reset (async assert, sync release): all outputs 0; RR pointer = cam0; read pipeline cleared. In-flight reads are discarded, and no disp_valid is produced for them after release.
- Arbitration is combinational in cycle T; exactly one or zero grants per cycle.
- Priority: disp_req > camera at RR pointer > other camera.
- Display is always accepted; there is no ready signal.
- camN_gnt is combinational in cycle T. A camera holds req/addr/data stable until it sees gnt. The transfer completes in the gnt cycle; the camera may present the next word in T+1.
- RR pointer: after a cam0 grant it points to cam1, and vice versa. It is unchanged on display or idle cycles.
- Both cameras requesting over 2 free cycles: cam0, then cam1 (from reset).
- RAM command is registered at T+1:
  - display grant: ram_re=1, ram_addr=disp_addr;
  - camera grant: ram_we=1, ram_addr/ram_wdata from that camera;
  - idle: ram_re=ram_we=0, ram_addr/ram_wdata hold their last value.
- ram_re and ram_we are never high together.
- Read return: a valid shift pipeline of depth RD_LAT tracks each ram_re. disp_data is registered from ram_rdata, and disp_valid pulses at T+2+RD_LAT (T+4 at default).
- Back-to-back display requests produce back-to-back disp_valid, in order, with no bubbles.
- disp_data holds its last value when disp_valid=0.
- Camera starvation while disp_req is continuous is permitted by design. Cameras receive slots during display blanking.
- Same-address camera write and display read in the same cycle: the read wins at T; the write happens at the earliest later free slot. The read returns the old data.

Optional Feature:
- Macro: FRAME_RAM_ARB_STATS_EN.
- When defined, adds outputs cam0_starve, cam1_starve (1 bit each, sticky) and grant_cnt (32 bit).
  - Per-camera wait counter: increments each cycle req=1 and gnt=0; clears on gnt; saturates at STARVE_LIMIT.
  - camN_starve sets when its counter reaches STARVE_LIMIT and stays set until reset.
  - grant_cnt counts every RAM command and wraps at 2^32.
- When not defined: these ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package frame_ram_pkg:
  - ADDR_W/PIX_W defaults;
  - requester enum {REQ_NONE, REQ_DISP, REQ_CAM0, REQ_CAM1};
  - pixel field slice constants for red/green/blue.
- One sub-module, rr_arb2: 2-way round-robin with pointer register. Inputs req[1:0] and an enable (low when display wins); outputs a one-hot gnt.
- Read-return pipeline stays inline.

Test Plan:
- Reset release, continuous disp_req, addresses 0,1,2…; RAM model RD_LAT=2 returning data=addr → disp_valid first at cycle 4, disp_data 0,1,2… gap-free; cam gnt never asserted.
- cam0_req and cam1_req held, disp_req=0 → gnt sequence cam0,cam1,cam0,cam1; ram_we every cycle; ram_wdata matches the granted camera.
- disp_req toggling 1,0,1,0 with both cameras requesting → ram_re/ram_we alternate; cameras are granted alternately in the display-free cycles.
- Write 0xFF0000 to addr 5 via cam1, then display read addr 5 → disp_data=0xFF0000 after 4 cycles. Simultaneous cam0 write 0x00FF00 and display read of addr 5 → read returns 0xFF0000; the write lands the next cycle.
- Reset asserted 1 cycle after 3 display reads issued → disp_valid stays 0 through and after release; all outputs 0 during reset.
- With FRAME_RAM_ARB_STATS_EN and STARVE_LIMIT=8: disp_req high for 10 cycles with cam0_req high → cam0_starve=1 at the 8th waiting cycle and stays 1; grant_cnt=10 at the end.
